fix_pipe_mul: RTL and testbench
===============================

FIX_PIPE_MUL -- requirements
Module: fix_pipe_mul

Interface
REQ-001 Parameter WIDTH_A, default 16: multiplicand width in bits.
REQ-002 Parameter WIDTH_B, default 16: multiplier width in bits.
REQ-003 Parameter BITS_PER_STAGE, default 4: multiplier bits retired per pipeline stage; must divide WIDTH_B.
REQ-004 Parameter TAG_W, default 4: width of the optional transaction tag.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  operand pair present.
REQ-008 in_ready  output  1  block accepts the operand pair this cycle.
REQ-009 is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 multiplicand  input  WIDTH_A  operand A.
REQ-011 multiplier  input  WIDTH_B  operand B.
REQ-012 in_tag  input  TAG_W  user tag; present only with FIX_PIPE_MUL_TAG_EN.
REQ-013 out_valid  output  1  product present.
REQ-014 out_ready  input  1  downstream accepts the product.
REQ-015 product  output  WIDTH_A+WIDTH_B  result, signed or unsigned per the captured is_signed.
REQ-016 out_tag  output  TAG_W  tag of the current product; present only with FIX_PIPE_MUL_TAG_EN.
REQ-017 busy  output  1  any stage holds a valid transaction.

Function
REQ-018 STAGES = WIDTH_B/BITS_PER_STAGE; each stage adds (A_mag * B_mag digit) << offset to its partial sum and registers the result.
REQ-019 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-020 Stall = out_valid && !out_ready; a stall freezes every stage register; in_ready = !stall.
REQ-021 Without a stall, latency from input transfer to out_valid is exactly STAGES cycles; throughput is one result per cycle.
REQ-022 Pipeline bubbles advance while not stalled; an invalid stage never raises out_valid.
REQ-023 Signed mode: operands are converted to magnitudes, and the result sign is A[msb] XOR B[msb], carried per stage; negation occurs in the final stage before the output register.
REQ-024 Signed boundary: -2^(WIDTH_A-1) * -2^(WIDTH_B-1) = +2^(WIDTH_A+WIDTH_B-2), exact, no overflow.
REQ-025 Unsigned mode: full-width exact product, no truncation or saturation.
REQ-026 Mixed is_signed values across back-to-back transactions are supported, each handled by its own captured bit.
REQ-027 product and out_tag hold stable while out_valid && !out_ready.
REQ-028 busy = OR of all stage valid bits.

Reset
REQ-029 rst clears every stage valid bit, out_valid=0, busy=0, product=0, out_tag=0; in_ready=1 during and after reset.
REQ-030 rst asserted mid-operation discards all in-flight transactions; no product from before rst ever appears.

Configuration
REQ-031 Macro FIX_PIPE_MUL_TAG_EN defined: in_tag/out_tag exist, and the tag travels with its transaction through all stages and stalls.
REQ-032 Macro undefined: tag ports and registers are absent; the remaining behaviour is identical.

Structure
REQ-033 Package fix_mul_pkg holds the stage-count function, width-derivation constants and the stage payload struct (valid, sign, partial sum, shifted operands, tag).
REQ-034 Sub-module fix_pipe_mul_stage implements one stage and is instantiated STAGES times via generate.

Verification (WIDTH_A=WIDTH_B=16, BITS_PER_STAGE=4, STAGES=4)
REQ-035 Unsigned 0xFFFF*0xFFFF, out_ready=1 -> out_valid exactly 4 cycles after transfer, product=0xFFFE0001.
REQ-036 Signed 0x8000*0x8000 -> product=0x40000000; signed 0xFFFF*0x0003 -> product=0xFFFFFFFD.
REQ-037 Ten back-to-back mixed-mode inputs, out_ready held low from cycle 6 to 9 -> in_ready=0 during the stall, no loss or duplication, results in order.
REQ-038 rst pulsed while 3 transactions are in flight -> out_valid=0 and busy=0 on the next cycle, no stale product afterwards.
REQ-039 With FIX_PIPE_MUL_TAG_EN, tags 0..9 sent with random out_ready -> out_tag sequence 0..9 matched to the correct products.

Source files
------------

// File: rtl/fix_mul_pkg.sv
// fix_mul_pkg
// Shared definitions for the pipelined fixed-point multiplier.
// Contents: maximum supported operand widths, the stage-count helper and
// the payload struct that travels from stage to stage.
// Optional feature macro: FIX_PIPE_MUL_TAG_EN adds a tag field to the payload.
// Ports: none (package).
package fix_mul_pkg;

    // Payload fields are sized for the widest supported configuration;
    // narrower instances leave the upper bits at zero and synthesis trims them.
    localparam int MAX_A   = 32;
    localparam int MAX_B   = 32;
    localparam int P_MAX   = MAX_A + MAX_B;
    localparam int MAX_TAG = 8;

    function automatic int stage_count(input int widthB, input int bitsPerStage);
        return widthB / bitsPerStage;
    endfunction

    // a_mag stays fixed; b_sh is shifted right one digit per stage so every
    // stage always consumes the low digit.
    typedef struct packed {
        logic               valid;
        logic               sign;
        logic [P_MAX-1:0]   psum;
        logic [MAX_A-1:0]   a_mag;
        logic [MAX_B-1:0]   b_sh;
`ifdef FIX_PIPE_MUL_TAG_EN
        logic [MAX_TAG-1:0] tag;
`endif
    } stage_t;

endpackage

// File: rtl/fix_pipe_mul_stage.sv
// fix_pipe_mul_stage
// One pipeline stage: adds (A magnitude * current B digit) << offset to the
// partial sum and registers the payload. The last stage also applies the
// result sign, so its register is the output register of the multiplier.
// Optional feature macro: FIX_PIPE_MUL_TAG_EN (tag field passes through).
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, clears the payload
//   en_i     advance enable; low freezes the stage
//   stage_i  payload from the previous stage
//   stage_o  registered payload
module fix_pipe_mul_stage
    import fix_mul_pkg::*;
#(
    parameter int BITS_PER_STAGE = 4,
    parameter int STAGE_IDX      = 0,
    parameter bit LAST           = 1'b0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en_i,
    input  stage_t stage_i,
    output stage_t stage_o
);

    localparam int DP_W   = MAX_A + BITS_PER_STAGE;
    localparam int OFFSET = STAGE_IDX * BITS_PER_STAGE;

    stage_t            stage_d;
    stage_t            stage_q;
    logic [DP_W-1:0]   digitProd;
    logic [P_MAX-1:0]  sumNext;

    // Partial-product accumulation and operand shift for this digit.
    always_comb begin
        stage_d   = stage_i;
        digitProd = DP_W'(stage_i.a_mag) * DP_W'(stage_i.b_sh[BITS_PER_STAGE-1:0]);
        sumNext   = stage_i.psum + (P_MAX'(digitProd) << OFFSET);
        // Magnitudes are multiplied throughout; the sign is applied once here.
        if (LAST && stage_i.sign) begin
            sumNext = -sumNext;
        end
        stage_d.psum = sumNext;
        stage_d.b_sh = stage_i.b_sh >> BITS_PER_STAGE;
    end

    // Stage register; holds its contents while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else if (en_i) begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/fix_pipe_mul.sv
// fix_pipe_mul
// Pipelined signed/unsigned multiplier retiring BITS_PER_STAGE multiplier
// bits per stage, with valid/ready handshakes on both sides.
// Optional feature macro: FIX_PIPE_MUL_TAG_EN adds in_tag/out_tag, a user
// tag carried alongside each transaction.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      input handshake
//   is_signed                operands are two's complement when 1
//   multiplicand, multiplier operands A and B
//   in_tag                   transaction tag (tag build only)
//   out_valid / out_ready    output handshake
//   product                  full-width product
//   out_tag                  tag of the presented product (tag build only)
//   busy                     some stage holds a valid transaction
module fix_pipe_mul
    import fix_mul_pkg::*;
#(
    parameter int WIDTH_A        = 16,
    parameter int WIDTH_B        = 16,
    parameter int BITS_PER_STAGE = 4,
    parameter int TAG_W          = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       is_signed,
    input  logic [WIDTH_A-1:0]         multiplicand,
    input  logic [WIDTH_B-1:0]         multiplier,
`ifdef FIX_PIPE_MUL_TAG_EN
    input  logic [TAG_W-1:0]           in_tag,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] product,
`ifdef FIX_PIPE_MUL_TAG_EN
    output logic [TAG_W-1:0]           out_tag,
`endif
    output logic                       busy
);

    localparam int STAGES = stage_count(WIDTH_B, BITS_PER_STAGE);
    localparam int PROD_W = WIDTH_A + WIDTH_B;

`ifndef FIX_PIPE_MUL_TAG_EN
    localparam int unusedTagW = TAG_W;
`endif

    logic               stall;
    logic               aNeg;
    logic               bNeg;
    logic [WIDTH_A-1:0] aMag;
    logic [WIDTH_B-1:0] bMag;
    stage_t             stageIn;
    stage_t             pipeOut [STAGES];
    logic               unusedFinal;

    // A presented but unaccepted product freezes the whole pipeline.
    // in_ready is forced high under reset since nothing is held then.
    assign stall    = out_valid && !out_ready;
    assign in_ready = rst || !stall;

    // Operand conditioning: magnitudes plus the result sign. Negating the
    // most negative value wraps to itself, which is the correct unsigned
    // magnitude.
    always_comb begin
        aNeg          = is_signed && multiplicand[WIDTH_A-1];
        bNeg          = is_signed && multiplier[WIDTH_B-1];
        aMag          = aNeg ? -multiplicand : multiplicand;
        bMag          = bNeg ? -multiplier : multiplier;
        stageIn       = '0;
        stageIn.valid = in_valid && in_ready;
        stageIn.sign  = aNeg ^ bNeg;
        stageIn.a_mag = MAX_A'(aMag);
        stageIn.b_sh  = MAX_B'(bMag);
`ifdef FIX_PIPE_MUL_TAG_EN
        stageIn.tag   = MAX_TAG'(in_tag);
`endif
    end

    // Stage chain; the last stage register is the output register.
    for (genvar g = 0; g < STAGES; g++) begin : gStage
        stage_t stIn;
        if (g == 0) begin : gFirst
            assign stIn = stageIn;
        end else begin : gRest
            assign stIn = pipeOut[g-1];
        end
        fix_pipe_mul_stage #(
            .BITS_PER_STAGE (BITS_PER_STAGE),
            .STAGE_IDX      (g),
            .LAST           (g == STAGES - 1)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (!stall),
            .stage_i (stIn),
            .stage_o (pipeOut[g])
        );
    end

    // busy reflects every stage, including the output register.
    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            busy = busy | pipeOut[s].valid;
        end
    end

    assign out_valid = pipeOut[STAGES-1].valid;
    assign product   = pipeOut[STAGES-1].psum[PROD_W-1:0];
`ifdef FIX_PIPE_MUL_TAG_EN
    assign out_tag   = pipeOut[STAGES-1].tag[TAG_W-1:0];
`endif

    // Operand fields are spent by the time the payload leaves the last stage.
    assign unusedFinal = ^pipeOut[STAGES-1];

endmodule

// File: tb/tb_fix_pipe_mul.sv
// tb_fix_pipe_mul
// Directed self-checking bench for fix_pipe_mul at 16x16, 4 bits per stage.
// Optional feature macro: FIX_PIPE_MUL_TAG_EN enables tag checking.
module tb_fix_pipe_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        is_signed;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;
`ifdef FIX_PIPE_MUL_TAG_EN
    logic [3:0]  in_tag;
    logic [3:0]  out_tag;
`endif

    int numChecks = 0;
    int numFails  = 0;

    // Back-to-back vectors with hand-computed products.
    logic        vecSigned [10];
    logic [15:0] vecA [10];
    logic [15:0] vecB [10];
    logic [31:0] vecP [10];

    always #5 clk = ~clk;

    fix_pipe_mul #(
        .WIDTH_A        (16),
        .WIDTH_B        (16),
        .BITS_PER_STAGE (4),
        .TAG_W          (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
`ifdef FIX_PIPE_MUL_TAG_EN
        .in_tag       (in_tag),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
`ifdef FIX_PIPE_MUL_TAG_EN
        .out_tag      (out_tag),
`endif
        .busy         (busy)
    );

    task automatic loadVectors();
        vecSigned[0] = 1'b0; vecA[0] = 16'h0003; vecB[0] = 16'h0005; vecP[0] = 32'h0000000F;
        vecSigned[1] = 1'b1; vecA[1] = 16'hFFFF; vecB[1] = 16'hFFFF; vecP[1] = 32'h00000001;
        vecSigned[2] = 1'b0; vecA[2] = 16'hFFFF; vecB[2] = 16'h0002; vecP[2] = 32'h0001FFFE;
        vecSigned[3] = 1'b1; vecA[3] = 16'hFFFF; vecB[3] = 16'h0002; vecP[3] = 32'hFFFFFFFE;
        vecSigned[4] = 1'b0; vecA[4] = 16'h0100; vecB[4] = 16'h0100; vecP[4] = 32'h00010000;
        vecSigned[5] = 1'b1; vecA[5] = 16'h8000; vecB[5] = 16'h0001; vecP[5] = 32'hFFFF8000;
        vecSigned[6] = 1'b0; vecA[6] = 16'h8000; vecB[6] = 16'h0001; vecP[6] = 32'h00008000;
        vecSigned[7] = 1'b1; vecA[7] = 16'h7FFF; vecB[7] = 16'h7FFF; vecP[7] = 32'h3FFF0001;
        vecSigned[8] = 1'b0; vecA[8] = 16'h0000; vecB[8] = 16'h1234; vecP[8] = 32'h00000000;
        vecSigned[9] = 1'b1; vecA[9] = 16'h0010; vecB[9] = 16'hFFF0; vecP[9] = 32'hFFFFFF00;
    endtask

    // Reset state, both while reset is held and right after release.
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        is_signed = 1'b0;
        multiplicand = '0;
        multiplier = '0;
`ifdef FIX_PIPE_MUL_TAG_EN
        in_tag = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        numChecks++;
        if (in_ready !== 1'b1) begin numFails++; $display("[TB] FAIL reset_in_ready_during: got %b expected 1", in_ready); end
        numChecks++;
        if (out_valid !== 1'b0) begin numFails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        numChecks++;
        if (busy !== 1'b0) begin numFails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        numChecks++;
        if (product !== 32'h0) begin numFails++; $display("[TB] FAIL reset_product: got %h expected 00000000", product); end
`ifdef FIX_PIPE_MUL_TAG_EN
        numChecks++;
        if (out_tag !== 4'h0) begin numFails++; $display("[TB] FAIL reset_out_tag: got %h expected 0", out_tag); end
`endif
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        numChecks++;
        if (in_ready !== 1'b1) begin numFails++; $display("[TB] FAIL reset_in_ready_after: got %b expected 1", in_ready); end
    endtask

    // Single unsigned max-value transaction with latency measurement.
    task automatic test_latency_unsigned();
        int edges;
        in_valid = 1'b1;
        is_signed = 1'b0;
        multiplicand = 16'hFFFF;
        multiplier = 16'hFFFF;
        out_ready = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        numChecks++;
        if (edges !== 4) begin numFails++; $display("[TB] FAIL latency: got %0d cycles expected 4", edges); end
        numChecks++;
        if (product !== 32'hFFFE0001) begin numFails++; $display("[TB] FAIL unsigned_max_product: got %h expected fffe0001", product); end
        @(posedge clk);
        @(negedge clk);
        numChecks++;
        if (out_valid !== 1'b0) begin numFails++; $display("[TB] FAIL single_no_duplicate: got out_valid %b expected 0", out_valid); end
    endtask

    // Sign boundaries and a mix of signed/unsigned single transactions.
    task automatic test_signed();
        logic        tSigned [6];
        logic [15:0] tA [6];
        logic [15:0] tB [6];
        logic [31:0] tP [6];
        int          waitCycles;
        tSigned[0] = 1'b1; tA[0] = 16'h8000; tB[0] = 16'h8000; tP[0] = 32'h40000000;
        tSigned[1] = 1'b1; tA[1] = 16'hFFFF; tB[1] = 16'h0003; tP[1] = 32'hFFFFFFFD;
        tSigned[2] = 1'b1; tA[2] = 16'h8000; tB[2] = 16'h7FFF; tP[2] = 32'hC0008000;
        tSigned[3] = 1'b1; tA[3] = 16'hFFFE; tB[3] = 16'hFFFD; tP[3] = 32'h00000006;
        tSigned[4] = 1'b0; tA[4] = 16'h1234; tB[4] = 16'h5678; tP[4] = 32'd103153760;
        tSigned[5] = 1'b0; tA[5] = 16'hFFFF; tB[5] = 16'h0003; tP[5] = 32'h0002FFFD;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            is_signed = tSigned[i];
            multiplicand = tA[i];
            multiplier = tB[i];
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            waitCycles = 0;
            while (!out_valid && waitCycles < 20) begin
                @(posedge clk);
                waitCycles++;
                @(negedge clk);
            end
            numChecks++;
            if (!out_valid) begin
                numFails++;
                $display("[TB] FAIL signed_case%0d_timeout: got no out_valid expected %h", i, tP[i]);
            end else if (product !== tP[i]) begin
                numFails++;
                $display("[TB] FAIL signed_case%0d: got %h expected %h", i, product, tP[i]);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Ten back-to-back transactions; fixed stall window or random out_ready.
    task automatic test_back_to_back(input bit randomReady);
        int sent = 0;
        int recv = 0;
        bit accIn;
        bit accOut;
        for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
            if (randomReady) out_ready = 1'($urandom_range(0, 1));
            else             out_ready = !(cyc >= 6 && cyc <= 9);
            in_valid = (sent < 10);
            if (sent < 10) begin
                is_signed = vecSigned[sent];
                multiplicand = vecA[sent];
                multiplier = vecB[sent];
`ifdef FIX_PIPE_MUL_TAG_EN
                in_tag = 4'(sent);
`endif
            end
            #1;
            if (out_valid && !out_ready) begin
                numChecks++;
                if (in_ready !== 1'b0) begin numFails++; $display("[TB] FAIL stall_in_ready cyc%0d: got %b expected 0", cyc, in_ready); end
            end
            if (out_valid) begin
                numChecks++;
                if (recv >= 10) begin
                    numFails++;
                    $display("[TB] FAIL b2b_extra_output: got product %h expected no output", product);
                end else if (product !== vecP[recv]) begin
                    numFails++;
                    $display("[TB] FAIL b2b_product%0d: got %h expected %h", recv, product, vecP[recv]);
                end
`ifdef FIX_PIPE_MUL_TAG_EN
                numChecks++;
                if (out_tag !== 4'(recv)) begin numFails++; $display("[TB] FAIL b2b_tag%0d: got %0d expected %0d", recv, out_tag, recv); end
`endif
            end
            accIn = in_valid && in_ready;
            accOut = out_valid && out_ready;
            @(posedge clk);
            if (accIn) sent++;
            if (accOut) recv++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        numChecks++;
        if (recv !== 10) begin numFails++; $display("[TB] FAIL b2b_count: got %0d results expected 10", recv); end
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        numChecks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL b2b_drain: got out_valid %b busy %b expected 0 0", out_valid, busy);
        end
    endtask

    // Reset with three transactions in flight discards all of them.
    task automatic test_reset_midflight();
        int staleSeen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            is_signed = vecSigned[i + 1];
            multiplicand = vecA[i + 1];
            multiplier = vecB[i + 1];
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        numChecks++;
        if (busy !== 1'b1) begin numFails++; $display("[TB] FAIL midflight_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        numChecks++;
        if (out_valid !== 1'b0) begin numFails++; $display("[TB] FAIL midflight_out_valid: got %b expected 0", out_valid); end
        numChecks++;
        if (busy !== 1'b0) begin numFails++; $display("[TB] FAIL midflight_busy_after: got %b expected 0", busy); end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) staleSeen++;
        end
        numChecks++;
        if (staleSeen !== 0) begin numFails++; $display("[TB] FAIL midflight_stale: got %0d stale outputs expected 0", staleSeen); end
    endtask

    initial begin
        loadVectors();
        test_reset();
        test_latency_unsigned();
        test_signed();
        test_back_to_back(1'b0);
        test_reset_midflight();
        test_back_to_back(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
